seg_scan_controller: RTL and testbench

//  Time-multiplexed scan scheduler for the 8-digit seven-segment display fed by the CPU-written
//  32-bit SEG register. Shares one cathode bus among 8 digits: one digit at a time, with dead-time

---
 rtl/seg_scan_controller_if.sv | 34 +++
 rtl/seg_scan_controller.sv | 191 +++++++++++++++++++
 tb/tb_seg_scan_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_controller_if.sv
// seg_scan_controller_if
//   Groups the display-controller signals into one bundle.
//   master : drives Enable, Value, Update, DPMask and observes the display outputs.
//   slave  : the scan controller itself.
//   Enable    : 1 = scan the display, 0 = all digits dark
//   Value     : 32-bit hex value, digit i = Value[4i+3:4i]
//   Update    : 1-cycle strobe requesting display of Value
//   DPMask    : decimal point per digit, 1 = lit (used live)
//   UpdAck    : 1-cycle pulse when a pending value enters the shadow
//   FrameDone : 1-cycle pulse when digit 7's slot ends and the scan wraps
//   AN        : anodes, active-low
//   CA        : cathodes {g,f,e,d,c,b,a}, active-low
//   DP        : decimal point cathode, active-low
interface seg_scan_controller_if;
    logic        Enable;
    logic [31:0] Value;
    logic        Update;
    logic [7:0]  DPMask;
    logic        UpdAck;
    logic        FrameDone;
    logic [7:0]  AN;
    logic [6:0]  CA;
    logic        DP;

    modport master (
        output Enable, Value, Update, DPMask,
        input  UpdAck, FrameDone, AN, CA, DP
    );

    modport slave (
        input  Enable, Value, Update, DPMask,
        output UpdAck, FrameDone, AN, CA, DP
    );
endinterface

// File: rtl/seg_scan_controller.sv
// seg_scan_controller
//   Time-multiplexed scan scheduler for an 8-digit seven-segment display.
//   Lights one digit per slot (REFRESH_DIV cycles) followed by DEAD_CYC dark
//   cycles. A value requested via Update is held pending and only copied into
//   the display shadow at a frame boundary (or at once while idle), so a frame
//   never shows a mix of old and new digits.
//   Ports:
//     CLK   : system clock, rising edge
//     Reset : asynchronous, active-low reset
//     bus   : slave side of seg_scan_controller_if (see interface header)
module seg_scan_controller #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYC    = 16,
    parameter bit BLANK_LEAD  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  Reset,
    seg_scan_controller_if.slave  bus
);

    localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYC) ? REFRESH_DIV : DEAD_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] RD_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DC_LAST = CW'((DEAD_CYC > 0) ? (DEAD_CYC - 1) : 0);

    typedef enum logic [1:0] {
        st_idle,
        st_scan,
        st_gap
    } state_t;

    state_t        state,   nxt_state;
    logic [2:0]    digit,   nxt_digit;
    logic [CW-1:0] cnt,     nxt_cnt;
    logic [31:0]   shadow,  nxt_shadow;
    logic [31:0]   pend_reg, nxt_pend;
    logic          pending, nxt_pending;
    logic          load_ack;
    logic          wrap;
    logic          advance;
    logic [3:0]    nib;
    logic          blank;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Next-state decode; the registered outputs below are derived from these
    // next values so the pins always match the state entered on the same edge.
    always_comb begin
        nxt_state   = state;
        nxt_digit   = digit;
        nxt_cnt     = cnt;
        nxt_shadow  = shadow;
        nxt_pend    = pend_reg;
        nxt_pending = pending;
        load_ack    = 1'b0;
        wrap        = 1'b0;
        advance     = 1'b0;

        if (bus.Update) begin
            nxt_pend    = bus.Value;
            nxt_pending = 1'b1;
        end

        case (state)
            st_idle: begin
                if (pending) begin
                    nxt_shadow = pend_reg;
                    load_ack   = 1'b1;
                    // A fresh Update in this cycle stays pending for the next load.
                    if (!bus.Update) begin
                        nxt_pending = 1'b0;
                    end
                end
                if (bus.Enable) begin
                    nxt_state = st_scan;
                    nxt_digit = '0;
                    nxt_cnt   = '0;
                end
            end
            st_scan, st_gap: begin
                if (!bus.Enable) begin
                    nxt_state = st_idle;
                    nxt_digit = '0;
                    nxt_cnt   = '0;
                end else if (state == st_scan) begin
                    if (cnt == RD_LAST) begin
                        nxt_cnt = '0;
                        if (DEAD_CYC > 0) begin
                            nxt_state = st_gap;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        nxt_cnt = cnt + 1'b1;
                    end
                end else begin
                    if (cnt == DC_LAST) begin
                        nxt_cnt = '0;
                        advance = 1'b1;
                    end else begin
                        nxt_cnt = cnt + 1'b1;
                    end
                end

                if (advance) begin
                    nxt_state = st_scan;
                    nxt_digit = digit + 3'd1;
                    if (digit == 3'd7) begin
                        wrap = 1'b1;
                        // Same-cycle Update wins: load Value directly.
                        if (bus.Update) begin
                            nxt_shadow  = bus.Value;
                            nxt_pending = 1'b0;
                            load_ack    = 1'b1;
                        end else if (pending) begin
                            nxt_shadow  = pend_reg;
                            nxt_pending = 1'b0;
                            load_ack    = 1'b1;
                        end
                    end
                end
            end
            default: begin
                nxt_state = st_idle;
                nxt_digit = '0;
                nxt_cnt   = '0;
            end
        endcase
    end

    // Leading-zero blanking: digit i>0 is dark when all higher-or-equal nibbles are zero.
    always_comb begin
        nib   = nxt_shadow[{nxt_digit, 2'b00} +: 4];
        blank = BLANK_LEAD && (nxt_digit != 3'd0) &&
                ((nxt_shadow >> {nxt_digit, 2'b00}) == '0);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state         <= st_idle;
            digit         <= '0;
            cnt           <= '0;
            shadow        <= '0;
            pend_reg      <= '0;
            pending       <= 1'b0;
            bus.AN        <= '1;
            bus.CA        <= '1;
            bus.DP        <= 1'b1;
            bus.UpdAck    <= 1'b0;
            bus.FrameDone <= 1'b0;
        end else begin
            state         <= nxt_state;
            digit         <= nxt_digit;
            cnt           <= nxt_cnt;
            shadow        <= nxt_shadow;
            pend_reg      <= nxt_pend;
            pending       <= nxt_pending;
            bus.UpdAck    <= load_ack;
            bus.FrameDone <= wrap;
            if (nxt_state == st_scan) begin
                bus.AN <= ~(8'b1 << nxt_digit);
                bus.CA <= blank ? 7'h7F : hex7(nib);
                bus.DP <= ~bus.DPMask[nxt_digit];
            end else begin
                bus.AN <= '1;
                bus.CA <= '1;
                bus.DP <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
module tb_seg_scan_controller;

    logic CLK;
    logic Reset;

    seg_scan_controller_if bus ();

    seg_scan_controller #(
        .REFRESH_DIV (4),
        .DEAD_CYC    (1),
        .BLANK_LEAD  (1'b1)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0]     val_a;
        bit              two;
        logic [31:0]     val_b;
        logic [7:0]      dpmask;
        logic [7:0][6:0] ca;   // expected CA per digit, index = digit
        logic [7:0]      dp;   // expected DP per digit, index = digit
    } vec_t;

    vec_t tab [5];
    int   n_tests;
    int   n_fail;

    // {AN, CA, DP, FrameDone, UpdAck}
    function automatic logic [17:0] exp_at(input int k, input vec_t v, input bit fd, input bit ack);
        int slot;
        int pos;
        logic [7:0] an;
        slot = k / 5;
        pos  = k % 5;
        if (pos < 4) begin
            an = ~(8'b1 << slot);
            exp_at = {an, v.ca[slot], v.dp[slot], 1'b0, 1'b0};
        end else begin
            exp_at = {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0};
        end
        if (k == 0) begin
            exp_at[1] = fd;
            exp_at[0] = ack;
        end
    endfunction

    task automatic chk(input string name, input logic [17:0] exp);
        logic [17:0] act;
        act = {bus.AN, bus.CA, bus.DP, bus.FrameDone, bus.UpdAck};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got AN=%h CA=%h DP=%b FD=%b ACK=%b, want AN=%h CA=%h DP=%b FD=%b ACK=%b",
                     name, act[17:10], act[9:3], act[2], act[1], act[0],
                     exp[17:10], exp[9:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Checks one 40-cycle frame; optionally issues the next record's Update(s)
    // mid-frame and sets its DPMask just before the wrap edge.
    task automatic run_frame(input int idx, input vec_t cur, input vec_t nxt,
                             input bit do_stim, input bit fd0, input bit ack0);
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            chk($sformatf("frame%0d_k%0d", idx, k), exp_at(k, cur, fd0, ack0));
            if (do_stim) begin
                if (k == 10) begin
                    bus.Update = 1'b1;
                    bus.Value  = nxt.val_a;
                end
                if (k == 11) bus.Update = 1'b0;
                if (nxt.two && k == 20) begin
                    bus.Update = 1'b1;
                    bus.Value  = nxt.val_b;
                end
                if (k == 21) bus.Update = 1'b0;
                if (k == 39) bus.DPMask = nxt.dpmask;
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        tab[0].val_a = 32'h0;        tab[0].two = 1'b0; tab[0].val_b = 32'h0;
        tab[0].dpmask = 8'h00;       tab[0].dp  = 8'hFF;
        tab[0].ca = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};

        tab[1].val_a = 32'h89ABCDEF; tab[1].two = 1'b0; tab[1].val_b = 32'h0;
        tab[1].dpmask = 8'h00;       tab[1].dp  = 8'hFF;
        tab[1].ca = {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        tab[2].val_a = 32'h00000305; tab[2].two = 1'b0; tab[2].val_b = 32'h0;
        tab[2].dpmask = 8'h04;       tab[2].dp  = 8'hFB;
        tab[2].ca = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h12};

        tab[3].val_a = 32'h00001111; tab[3].two = 1'b1; tab[3].val_b = 32'h00002222;
        tab[3].dpmask = 8'h00;       tab[3].dp  = 8'hFF;
        tab[3].ca = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h24, 7'h24, 7'h24};

        tab[4].val_a = 32'h00000005; tab[4].two = 1'b0; tab[4].val_b = 32'h0;
        tab[4].dpmask = 8'h04;       tab[4].dp  = 8'hFB;
        tab[4].ca = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12};

        Reset      = 1'b0;
        bus.Enable = 1'b1;
        bus.Update = 1'b0;
        bus.Value  = 32'h0;
        bus.DPMask = 8'h00;

        @(negedge CLK);
        chk("reset_state", {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
        @(negedge CLK);
        Reset = 1'b1;

        // Table-driven frames: each record is shown in its frame, the next
        // record's Update is issued mid-frame and must not appear until the wrap.
        for (int i = 0; i < 5; i++) begin
            run_frame(i, tab[i], tab[(i < 4) ? i + 1 : 0], (i < 4), (i > 0), (i > 0));
        end

        // Update in the very cycle of the 7->0 advance loads directly.
        bus.Update = 1'b1;
        bus.Value  = 32'h00000007;
        bus.DPMask = 8'h00;
        @(negedge CLK);
        bus.Update = 1'b0;
        chk("wrap_update_k0", {8'hFE, 7'h78, 1'b1, 1'b1, 1'b1});
        @(negedge CLK);
        chk("wrap_update_k1", {8'hFE, 7'h78, 1'b1, 1'b0, 1'b0});

        // Drop Enable mid digit 3.
        repeat (15) @(negedge CLK);
        chk("digit3_scan", {8'hF7, 7'h7F, 1'b1, 1'b0, 1'b0});
        bus.Enable = 1'b0;
        @(negedge CLK);
        chk("disable_dark", {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});

        // Update while idle: capture, then load with UpdAck.
        bus.Update = 1'b1;
        bus.Value  = 32'h00000001;
        @(negedge CLK);
        bus.Update = 1'b0;
        chk("idle_capture", {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
        @(negedge CLK);
        chk("idle_updack", {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1});
        @(negedge CLK);
        chk("idle_updack_end", {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});

        // Re-enable restarts at digit 0 with a full slot.
        bus.Enable = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            chk($sformatf("reen_d0_c%0d", c), {8'hFE, 7'h79, 1'b1, 1'b0, 1'b0});
        end
        @(negedge CLK);
        chk("reen_gap", {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
        @(negedge CLK);
        chk("reen_d1", {8'hFD, 7'h7F, 1'b1, 1'b0, 1'b0});

        // Capture a value, then reset asynchronously mid-scan: dark at once, pending lost.
        bus.Update = 1'b1;
        bus.Value  = 32'h00000009;
        @(negedge CLK);
        bus.Update = 1'b0;
        chk("pre_reset_d1", {8'hFD, 7'h7F, 1'b1, 1'b0, 1'b0});
        #2 Reset = 1'b0;
        #1 chk("async_reset", {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
        @(negedge CLK);
        chk("reset_hold", {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
        Reset = 1'b1;
        run_frame(9, tab[0], tab[0], 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("post_reset_wrap", {8'hFE, 7'h40, 1'b1, 1'b1, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
